// File: rtl/ackcts_responder_pkg.sv
// Shared xpu definitions for the ACK/CTS responder: frame-control codes,
// legacy rate codes, RTS length, FSM encoding and the Duration helper.
package ackcts_responder_pkg;

    localparam logic [1:0] FC_TYPE_MGMT = 2'b00;
    localparam logic [1:0] FC_TYPE_CTRL = 2'b01;
    localparam logic [1:0] FC_TYPE_DATA = 2'b10;

    localparam logic [3:0] FC_SUBTYPE_RTS = 4'b1011;

    localparam logic [15:0] RTS_LEN = 16'd20;

    localparam logic [3:0] RATE_6M  = 4'b1011;
    localparam logic [3:0] RATE_9M  = 4'b1111;
    localparam logic [3:0] RATE_12M = 4'b1010;
    localparam logic [3:0] RATE_18M = 4'b1110;
    localparam logic [3:0] RATE_24M = 4'b1001;
    localparam logic [3:0] RATE_36M = 4'b1101;
    localparam logic [3:0] RATE_48M = 4'b1000;
    localparam logic [3:0] RATE_54M = 4'b1100;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_ADDR,
        ST_FCS,
        ST_SIFS,
        ST_REQ
    } state_e;

    // Remaining NAV after our response: dur - SIFS - resp_time, floored at 0.
    // A received duration with bit 15 set is not a NAV value, so it yields 0.
    function automatic logic [15:0] calc_resp_dur(
        input logic [15:0] dur,
        input logic [6:0]  sifs,
        input logic [11:0] rtime
    );
        logic [15:0] total;
        logic [15:0] avail;
        logic [15:0] res;
        total = {9'd0, sifs} + {4'd0, rtime};
        avail = {1'b0, dur[14:0]};
        res   = 16'd0;
        if (!dur[15] && (avail >= total)) begin
            res = avail - total;
        end
        return res;
    endfunction

endpackage

// File: rtl/ackcts_rate_sel.sv
// Response rate selection: maps received rate/MCS to the control response
// rate and its OFDM symbol count.
// Ports: signal_rate_i ([7]=HT, [3:0]=rate/MCS) -> resp_rate_o, n_sym_o.
module ackcts_rate_sel
    import ackcts_responder_pkg::*;
(
    input  logic [7:0] signal_rate_i,
    output logic [7:0] resp_rate_o,
    output logic [2:0] n_sym_o
);

    logic [3:0] code;
    logic       unused_rate_bits;

    assign unused_rate_bits = ^signal_rate_i[6:4];

    always_comb begin
        code = RATE_6M;
        if (signal_rate_i[7]) begin
            case (signal_rate_i[3:0])
                4'd0:       code = RATE_6M;
                4'd1, 4'd2: code = RATE_12M;
                default:    code = RATE_24M;
            endcase
        end else begin
            case (signal_rate_i[3:0])
                RATE_6M, RATE_9M:   code = RATE_6M;
                RATE_12M, RATE_18M: code = RATE_12M;
                RATE_24M, RATE_36M,
                RATE_48M, RATE_54M: code = RATE_24M;
                // Unknown legacy code: answer at the most robust rate.
                default:            code = RATE_6M;
            endcase
        end
    end

    always_comb begin
        n_sym_o = 3'd2;
        case (code)
            RATE_6M:  n_sym_o = 3'd6;
            RATE_12M: n_sym_o = 3'd3;
            default:  n_sym_o = 3'd2;
        endcase
    end

    assign resp_rate_o = {4'b0000, code};

endmodule

// File: rtl/ackcts_responder.sv
// Receiver-side ACK/CTS responder: after a good unicast frame to this node,
// waits SIFS (minus TX lead) and requests an ACK, or a CTS after an RTS.
// Ports: PHY rx strobes (header/FC/addr/FCS), timing config (sifs, preamble,
// symbol time), resp_enable/nav_busy/resp_ack in; resp_req, resp_is_cts,
// resp_ra, resp_duration, resp_rate, resp_drop, resp_drop_count out.
// Macro ACKCTS_RESP_CTS_EN enables the RTS->CTS path.
module ackcts_responder
    import ackcts_responder_pkg::*;
#(
    parameter int TX_LEAD_US      = 2,
    parameter int RESP_TIMEOUT_US = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tsf_pulse_1M,
    input  logic        pkt_header_valid_strobe,
    input  logic        pkt_header_valid,
    input  logic [7:0]  signal_rate,
    input  logic [15:0] signal_len,
    input  logic        FC_DI_valid,
    input  logic [1:0]  FC_type,
    input  logic [3:0]  FC_subtype,
    input  logic [15:0] duration,
    input  logic        addr1_valid,
    input  logic        addr2_valid,
    input  logic [47:0] addr1,
    input  logic [47:0] addr2,
    input  logic [47:0] self_mac_addr,
    input  logic        fcs_in_strobe,
    input  logic        fcs_valid,
    input  logic [6:0]  sifs_time,
    input  logic [6:0]  preamble_sig_time,
    input  logic [4:0]  ofdm_symbol_time,
    input  logic        resp_enable,
    input  logic        nav_busy,
    input  logic        resp_ack,
    output logic        resp_req,
    output logic        resp_is_cts,
    output logic [47:0] resp_ra,
    output logic [15:0] resp_duration,
    output logic [7:0]  resp_rate,
    output logic        resp_drop,
    output logic [15:0] resp_drop_count
);

    localparam logic [6:0] LEAD    = 7'(TX_LEAD_US);
    localparam logic [7:0] TMO_LIM = 8'(RESP_TIMEOUT_US);

    state_e      state_q, state_d;
    logic [6:0]  sifs_cnt_q, sifs_cnt_d;
    logic [7:0]  tmo_q, tmo_d;
    logic        cts_cap_q, cts_cap_d;
    logic [15:0] dur_cap_q, dur_cap_d;
    logic [7:0]  rate_cap_q, rate_cap_d;
    logic [47:0] ra_q, ra_d;
    logic        req_q, req_d;
    logic        cts_q, cts_d;
    logic [15:0] dur_o_q, dur_o_d;
    logic [7:0]  rate_o_q, rate_o_d;
    logic        drop_q, drop_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    logic        drop_evt;
    logic        is_ack_frame;
    logic        is_rts_frame;
    logic        nav_block;
    logic [7:0]  sel_rate;
    logic [2:0]  n_sym;
    logic [11:0] resp_time;
    logic [6:0]  sifs_load;

    ackcts_rate_sel u_rate_sel (
        .signal_rate_i (rate_cap_q),
        .resp_rate_o   (sel_rate),
        .n_sym_o       (n_sym)
    );

    assign resp_time = 12'(preamble_sig_time)
                     + 12'(ofdm_symbol_time) * 12'(n_sym);

    assign sifs_load = (sifs_time > LEAD) ? (sifs_time - LEAD) : 7'd0;

    assign is_ack_frame = (FC_type == FC_TYPE_MGMT)
                       || (FC_type == FC_TYPE_DATA);

`ifdef ACKCTS_RESP_CTS_EN
    assign is_rts_frame = (FC_type == FC_TYPE_CTRL)
                       && (FC_subtype == FC_SUBTYPE_RTS)
                       && (signal_len == RTS_LEN)
                       && !duration[15];
    assign nav_block    = nav_busy;
`else
    logic unused_cts_inputs;
    assign unused_cts_inputs = ^{nav_busy, signal_len, FC_subtype};
    assign is_rts_frame = 1'b0;
    assign nav_block    = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        sifs_cnt_d = sifs_cnt_q;
        tmo_d      = tmo_q;
        cts_cap_d  = cts_cap_q;
        dur_cap_d  = dur_cap_q;
        rate_cap_d = rate_cap_q;
        ra_d       = ra_q;
        req_d      = req_q;
        cts_d      = cts_q;
        dur_o_d    = dur_o_q;
        rate_o_d   = rate_o_q;
        drop_evt   = 1'b0;

        unique case (state_q)
            ST_IDLE: ;
            ST_HDR: begin
                if (FC_DI_valid) begin
                    dur_cap_d  = duration;
                    rate_cap_d = signal_rate;
                    if (is_ack_frame) begin
                        cts_cap_d = 1'b0;
                        state_d   = ST_ADDR;
                    end else if (is_rts_frame) begin
                        cts_cap_d = 1'b1;
                        state_d   = ST_ADDR;
                    end else begin
                        state_d   = ST_IDLE;
                    end
                end
            end
            ST_ADDR: begin
                if (addr2_valid) begin
                    ra_d = addr2;
                end
                if (addr1_valid) begin
                    // Unicast to us only; group bit set means no response.
                    if ((addr1 == self_mac_addr) && !addr1[0]) begin
                        state_d = ST_FCS;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_FCS: begin
                if (addr2_valid) begin
                    ra_d = addr2;
                end
                if (fcs_in_strobe) begin
                    if (!fcs_valid || !resp_enable
                        || (cts_cap_q && nav_block)) begin
                        state_d = ST_IDLE;
                    end else begin
                        // Response fields are latched now so they are
                        // already stable when resp_req rises.
                        cts_d      = cts_cap_q;
                        rate_o_d   = sel_rate;
                        dur_o_d    = calc_resp_dur(dur_cap_q, sifs_time,
                                                   resp_time);
                        sifs_cnt_d = sifs_load;
                        tmo_d      = 8'd0;
                        if (sifs_load == 7'd0) begin
                            req_d   = 1'b1;
                            state_d = ST_REQ;
                        end else begin
                            state_d = ST_SIFS;
                        end
                    end
                end
            end
            ST_SIFS: begin
                if (tsf_pulse_1M) begin
                    if (sifs_cnt_q <= 7'd1) begin
                        sifs_cnt_d = 7'd0;
                        req_d      = 1'b1;
                        state_d    = ST_REQ;
                    end else begin
                        sifs_cnt_d = sifs_cnt_q - 7'd1;
                    end
                end
            end
            ST_REQ: begin
                // Ack has priority over a same-cycle timeout.
                if (resp_ack) begin
                    req_d   = 1'b0;
                    state_d = ST_IDLE;
                end else if (tsf_pulse_1M) begin
                    if (tmo_q >= TMO_LIM) begin
                        req_d    = 1'b0;
                        drop_evt = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        tmo_d = tmo_q + 8'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A new PHY header pre-empts whatever is in flight; a pending or
        // waiting response is lost unless it was acked this very cycle.
        if (pkt_header_valid_strobe) begin
            state_d = pkt_header_valid ? ST_HDR : ST_IDLE;
            req_d   = 1'b0;
            if ((state_q == ST_SIFS)
                || ((state_q == ST_REQ) && !resp_ack)) begin
                drop_evt = 1'b1;
            end
        end

        drop_d     = drop_evt;
        drop_cnt_d = drop_cnt_q;
        if (drop_evt && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            sifs_cnt_q <= 7'd0;
            tmo_q      <= 8'd0;
            cts_cap_q  <= 1'b0;
            dur_cap_q  <= 16'd0;
            rate_cap_q <= 8'd0;
            ra_q       <= 48'd0;
            req_q      <= 1'b0;
            cts_q      <= 1'b0;
            dur_o_q    <= 16'd0;
            rate_o_q   <= 8'd0;
            drop_q     <= 1'b0;
            drop_cnt_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            sifs_cnt_q <= sifs_cnt_d;
            tmo_q      <= tmo_d;
            cts_cap_q  <= cts_cap_d;
            dur_cap_q  <= dur_cap_d;
            rate_cap_q <= rate_cap_d;
            ra_q       <= ra_d;
            req_q      <= req_d;
            cts_q      <= cts_d;
            dur_o_q    <= dur_o_d;
            rate_o_q   <= rate_o_d;
            drop_q     <= drop_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign resp_req        = req_q;
    assign resp_is_cts     = cts_q;
    assign resp_ra         = ra_q;
    assign resp_duration   = dur_o_q;
    assign resp_rate       = rate_o_q;
    assign resp_drop       = drop_q;
    assign resp_drop_count = drop_cnt_q;

endmodule

// File: tb/tb_ackcts_responder.sv
// Directed testbench for ackcts_responder with a response scoreboard.
// Expected responses are queued as frames are sent and popped on resp_req.
module tb_ackcts_responder;

    typedef struct {
        logic        is_cts;
        logic [47:0] ra;
        logic [15:0] dur;
        logic [7:0]  rate;
    } exp_t;

    localparam logic [47:0] SELF  = 48'h0A1B2C3D4E50;
    localparam logic [47:0] PEER  = 48'h66778899AABC;
    localparam logic [47:0] OTHER = 48'h0A1B2C3D4E52;

    logic        clk = 1'b0;
    logic        rst;
    logic        tsf_pulse_1M;
    logic        pkt_header_valid_strobe;
    logic        pkt_header_valid;
    logic [7:0]  signal_rate;
    logic [15:0] signal_len;
    logic        FC_DI_valid;
    logic [1:0]  FC_type;
    logic [3:0]  FC_subtype;
    logic [15:0] duration;
    logic        addr1_valid;
    logic        addr2_valid;
    logic [47:0] addr1;
    logic [47:0] addr2;
    logic [47:0] self_mac_addr;
    logic        fcs_in_strobe;
    logic        fcs_valid;
    logic [6:0]  sifs_time;
    logic [6:0]  preamble_sig_time;
    logic [4:0]  ofdm_symbol_time;
    logic        resp_enable;
    logic        nav_busy;
    logic        resp_ack;
    logic        resp_req;
    logic        resp_is_cts;
    logic [47:0] resp_ra;
    logic [15:0] resp_duration;
    logic [7:0]  resp_rate;
    logic        resp_drop;
    logic [15:0] resp_drop_count;

    int   checks = 0;
    int   errors = 0;
    int   tsf_seen = 0;
    int   drop_seen = 0;
    int   frame_start = 0;
    logic prev_req = 1'b0;
    exp_t sb[$];
    exp_t mon_e;

    ackcts_responder #(
        .TX_LEAD_US      (2),
        .RESP_TIMEOUT_US (4)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .tsf_pulse_1M            (tsf_pulse_1M),
        .pkt_header_valid_strobe (pkt_header_valid_strobe),
        .pkt_header_valid        (pkt_header_valid),
        .signal_rate             (signal_rate),
        .signal_len              (signal_len),
        .FC_DI_valid             (FC_DI_valid),
        .FC_type                 (FC_type),
        .FC_subtype              (FC_subtype),
        .duration                (duration),
        .addr1_valid             (addr1_valid),
        .addr2_valid             (addr2_valid),
        .addr1                   (addr1),
        .addr2                   (addr2),
        .self_mac_addr           (self_mac_addr),
        .fcs_in_strobe           (fcs_in_strobe),
        .fcs_valid               (fcs_valid),
        .sifs_time               (sifs_time),
        .preamble_sig_time       (preamble_sig_time),
        .ofdm_symbol_time        (ofdm_symbol_time),
        .resp_enable             (resp_enable),
        .nav_busy                (nav_busy),
        .resp_ack                (resp_ack),
        .resp_req                (resp_req),
        .resp_is_cts             (resp_is_cts),
        .resp_ra                 (resp_ra),
        .resp_duration           (resp_duration),
        .resp_rate               (resp_rate),
        .resp_drop               (resp_drop),
        .resp_drop_count         (resp_drop_count)
    );

    always #5 clk = ~clk;

    // 1 us tick: one cycle high every 10 cycles.
    initial begin
        tsf_pulse_1M = 1'b0;
        forever begin
            repeat (9) @(negedge clk);
            tsf_pulse_1M = 1'b1;
            @(negedge clk);
            tsf_pulse_1M = 1'b0;
        end
    end

    always @(posedge clk) begin
        if (tsf_pulse_1M) tsf_seen <= tsf_seen + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: every resp_req rising edge consumes one entry.
    always @(negedge clk) begin
        prev_req <= resp_req;
        if (resp_drop) drop_seen <= drop_seen + 1;
        if (!rst && resp_req && !prev_req) begin
            if (sb.size() == 0) begin
                chk("unexpected_req", {63'd0, resp_req}, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("resp_is_cts", {63'd0, resp_is_cts}, {63'd0, mon_e.is_cts});
                chk("resp_ra", {16'd0, resp_ra}, {16'd0, mon_e.ra});
                chk("resp_duration", {48'd0, resp_duration}, {48'd0, mon_e.dur});
                chk("resp_rate", {56'd0, resp_rate}, {56'd0, mon_e.rate});
            end
        end
    end

    task automatic push(input logic cts, input logic [15:0] dur,
                        input logic [7:0] rate);
        exp_t e;
        e.is_cts = cts;
        e.ra     = PEER;
        e.dur    = dur;
        e.rate   = rate;
        sb.push_back(e);
    endtask

    task automatic send_frame(
        input logic [1:0]  ft,
        input logic [3:0]  fs,
        input logic [15:0] len,
        input logic [15:0] dur,
        input logic [7:0]  rate,
        input logic [47:0] a1,
        input logic        fok
    );
        pkt_header_valid_strobe = 1'b1;
        pkt_header_valid = 1'b1;
        signal_rate = rate;
        signal_len = len;
        @(negedge clk);
        pkt_header_valid_strobe = 1'b0;
        FC_DI_valid = 1'b1;
        FC_type = ft;
        FC_subtype = fs;
        duration = dur;
        @(negedge clk);
        FC_DI_valid = 1'b0;
        addr1_valid = 1'b1;
        addr2_valid = 1'b1;
        addr1 = a1;
        addr2 = PEER;
        @(negedge clk);
        addr1_valid = 1'b0;
        addr2_valid = 1'b0;
        repeat (3) @(negedge clk);
        fcs_in_strobe = 1'b1;
        fcs_valid = fok;
        @(negedge clk);
        fcs_in_strobe = 1'b0;
        fcs_valid = 1'b0;
        frame_start = tsf_seen;
    endtask

    task automatic wait_req(output logic found, output int pulses,
                            output int cycles);
        found = 1'b0;
        cycles = 0;
        for (int i = 0; i < 400; i++) begin
            if (resp_req) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
            cycles++;
        end
        pulses = tsf_seen - frame_start;
    endtask

    task automatic do_ack(input string tag);
        resp_ack = 1'b1;
        @(negedge clk);
        resp_ack = 1'b0;
        chk({tag, "_req_low"}, {63'd0, resp_req}, 64'd0);
        chk({tag, "_no_drop"}, {63'd0, resp_drop}, 64'd0);
    endtask

    initial begin
        logic found;
        int   pulses;
        int   cycles;
        int   t0;

        rst = 1'b1;
        pkt_header_valid_strobe = 1'b0;
        pkt_header_valid = 1'b0;
        signal_rate = 8'd0;
        signal_len = 16'd0;
        FC_DI_valid = 1'b0;
        FC_type = 2'd0;
        FC_subtype = 4'd0;
        duration = 16'd0;
        addr1_valid = 1'b0;
        addr2_valid = 1'b0;
        addr1 = 48'd0;
        addr2 = 48'd0;
        self_mac_addr = SELF;
        fcs_in_strobe = 1'b0;
        fcs_valid = 1'b0;
        sifs_time = 7'd16;
        preamble_sig_time = 7'd20;
        ofdm_symbol_time = 5'd4;
        resp_enable = 1'b1;
        nav_busy = 1'b0;
        resp_ack = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_req", {63'd0, resp_req}, 64'd0);
        chk("rst_cts", {63'd0, resp_is_cts}, 64'd0);
        chk("rst_ra", {16'd0, resp_ra}, 64'd0);
        chk("rst_dur", {48'd0, resp_duration}, 64'd0);
        chk("rst_rate", {56'd0, resp_rate}, 64'd0);
        chk("rst_drop", {63'd0, resp_drop}, 64'd0);
        chk("rst_cnt", {48'd0, resp_drop_count}, 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Data, legacy 54M: resp_time 20+4*2=28, 44-16-28=0.
        push(1'b0, 16'd0, 8'h09);
        send_frame(2'b10, 4'b0000, 16'd100, 16'd44, 8'h0C, SELF, 1'b1);
        wait_req(found, pulses, cycles);
        chk("ack54_found", {63'd0, found}, 64'd1);
        chk("ack54_lat_us", 64'(pulses), 64'd14);
        do_ack("ack54");

        // Duration bit 15 set on data frame -> response duration 0, 6M.
        push(1'b0, 16'd0, 8'h0B);
        send_frame(2'b10, 4'b0000, 16'd100, 16'h8123, 8'h0B, SELF, 1'b1);
        wait_req(found, pulses, cycles);
        chk("dur15_found", {63'd0, found}, 64'd1);
        do_ack("dur15");

        // HT MCS2 -> 12M, n_sym 3: 100-16-(20+12)=52.
        push(1'b0, 16'd52, 8'h0A);
        send_frame(2'b10, 4'b0000, 16'd100, 16'd100, 8'h82, SELF, 1'b1);
        wait_req(found, pulses, cycles);
        chk("ht_found", {63'd0, found}, 64'd1);
        do_ack("ht");

        // SIFS shorter than TX lead: request one cycle after FCS strobe.
        sifs_time = 7'd2;
        push(1'b0, 16'd70, 8'h09);
        send_frame(2'b10, 4'b0000, 16'd100, 16'd100, 8'h0C, SELF, 1'b1);
        wait_req(found, pulses, cycles);
        chk("sifs0_found", {63'd0, found}, 64'd1);
        chk("sifs0_cycles", 64'(cycles), 64'd0);
        do_ack("sifs0");
        sifs_time = 7'd16;

        // Not addressed to us, then bad FCS: no response.
        send_frame(2'b10, 4'b0000, 16'd100, 16'd44, 8'h0C, OTHER, 1'b1);
        wait_req(found, pulses, cycles);
        chk("addr_mismatch_noreq", {63'd0, found}, 64'd0);
        send_frame(2'b10, 4'b0000, 16'd100, 16'd44, 8'h0C, SELF, 1'b0);
        wait_req(found, pulses, cycles);
        chk("bad_fcs_noreq", {63'd0, found}, 64'd0);

`ifdef ACKCTS_RESP_CTS_EN
        // RTS at 6M: resp_time 20+24=44, 300-16-44=240.
        push(1'b1, 16'd240, 8'h0B);
        send_frame(2'b01, 4'b1011, 16'd20, 16'd300, 8'h0B, SELF, 1'b1);
        wait_req(found, pulses, cycles);
        chk("cts_found", {63'd0, found}, 64'd1);
        do_ack("cts");
        nav_busy = 1'b1;
        send_frame(2'b01, 4'b1011, 16'd20, 16'd300, 8'h0B, SELF, 1'b1);
        wait_req(found, pulses, cycles);
        chk("cts_nav_noreq", {63'd0, found}, 64'd0);
        nav_busy = 1'b0;
`else
        send_frame(2'b01, 4'b1011, 16'd20, 16'd300, 8'h0B, SELF, 1'b1);
        wait_req(found, pulses, cycles);
        chk("rts_disabled_noreq", {63'd0, found}, 64'd0);
        chk("rts_disabled_cts0", {63'd0, resp_is_cts}, 64'd0);
`endif

        // New header during SIFS: response dropped.
        send_frame(2'b10, 4'b0000, 16'd100, 16'd44, 8'h0C, SELF, 1'b1);
        repeat (50) @(negedge clk);
        pkt_header_valid_strobe = 1'b1;
        pkt_header_valid = 1'b0;
        @(negedge clk);
        pkt_header_valid_strobe = 1'b0;
        chk("sifs_drop_pulse", {63'd0, resp_drop}, 64'd1);
        chk("sifs_drop_cnt", {48'd0, resp_drop_count}, 64'd1);
        repeat (200) @(negedge clk);
        chk("sifs_drop_noreq", {63'd0, resp_req}, 64'd0);

        // Ack withheld: timeout after the 5th us tick in REQ.
        push(1'b0, 16'd0, 8'h09);
        send_frame(2'b10, 4'b0000, 16'd100, 16'd44, 8'h0C, SELF, 1'b1);
        wait_req(found, pulses, cycles);
        chk("tmo_found", {63'd0, found}, 64'd1);
        t0 = tsf_seen;
        for (int i = 0; i < 200; i++) begin
            if (!resp_req) break;
            @(negedge clk);
        end
        chk("tmo_req_low", {63'd0, resp_req}, 64'd0);
        chk("tmo_drop_pulse", {63'd0, resp_drop}, 64'd1);
        chk("tmo_us", 64'(tsf_seen - t0), 64'd5);
        chk("tmo_cnt", {48'd0, resp_drop_count}, 64'd2);

        // Ack on first REQ cycle: clean return, no drop.
        push(1'b0, 16'd0, 8'h09);
        send_frame(2'b10, 4'b0000, 16'd100, 16'd44, 8'h0C, SELF, 1'b1);
        wait_req(found, pulses, cycles);
        chk("fast_ack_found", {63'd0, found}, 64'd1);
        do_ack("fast_ack");
        chk("fast_ack_cnt", {48'd0, resp_drop_count}, 64'd2);

        // Ack together with a new header: ack wins, no drop.
        push(1'b0, 16'd0, 8'h09);
        send_frame(2'b10, 4'b0000, 16'd100, 16'd44, 8'h0C, SELF, 1'b1);
        wait_req(found, pulses, cycles);
        chk("ack_hdr_found", {63'd0, found}, 64'd1);
        pkt_header_valid_strobe = 1'b1;
        pkt_header_valid = 1'b1;
        do_ack("ack_hdr");
        pkt_header_valid_strobe = 1'b0;
        chk("ack_hdr_cnt", {48'd0, resp_drop_count}, 64'd2);
        pkt_header_valid_strobe = 1'b1;
        pkt_header_valid = 1'b0;
        @(negedge clk);
        pkt_header_valid_strobe = 1'b0;
        repeat (200) @(negedge clk);
        chk("ack_hdr_noreq", {63'd0, resp_req}, 64'd0);

        chk("drop_pulses_total", 64'(drop_seen), 64'd2);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
